// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR with one shared signed MAC.
// Owns the sample history and a double-buffered coefficient bank.
module fir_mac_sequencer #(
   parameter int NTAPS  = 128,
   parameter int COEF_W = 16,
   parameter int SAMP_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NTAPS*COEF_W-1:0]   allTaps,
   input  logic                      tapsValid,
   input  logic [SAMP_W-1:0]         sampleIn,
   input  logic                      sampleValid,
   output logic                      sampleReady,
   output logic [SAMP_W-1:0]         sampleOut,
   output logic                      outValid,
   output logic                      busy
);

   localparam int PW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int PRD_W = COEF_W + SAMP_W;
   localparam int TOP_W = ACC_W - SAMP_W + 1;
   localparam logic [PW-1:0] LAST = PW'(NTAPS - 1);
   localparam logic [PW-1:0] NT_P = PW'(NTAPS);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t state, state_nx;

   logic [SAMP_W-1:0]        hist [NTAPS];
   logic [COEF_W-1:0]        coef [NTAPS];
   logic [NTAPS*COEF_W-1:0]  shadow;
   logic                     pending;
   logic [PW-1:0]            wr_ptr, base, idx, rd_ptr;
   logic signed [ACC_W-1:0]  acc, shifted, prod_ext;
   logic signed [PRD_W-1:0]  prod;
   logic [TOP_W-1:0]         top;
   logic [SAMP_W-1:0]        sat_val;
   logic                     accept, bank_load;

   assign accept    = (state == IDLE) && sampleValid;
   assign bank_load = (state == IDLE) && (tapsValid || pending);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: one MAC pass per accepted sample, then one OUT cycle
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = MAC;
         MAC:     if (idx == LAST) state_nx = OUT;
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      sampleReady = (state == IDLE);
      busy        = (state != IDLE);
   end

   // History read pointer (base - idx) mod NTAPS, wrap-safe for any NTAPS
   always_comb begin
      rd_ptr = base - idx;
      if (base < idx) rd_ptr = base - idx + NT_P;
   end

   // Signed product sign-extended to accumulator width, and output saturation
   always_comb begin
      prod     = $signed(coef[idx]) * $signed(hist[rd_ptr]);
      prod_ext = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};
      shifted  = acc >>> (COEF_W - 1);
      top      = shifted[ACC_W-1:SAMP_W-1];
      sat_val  = shifted[SAMP_W-1:0];
      if (!((&top) || (~|top))) begin
         if (shifted[ACC_W-1]) sat_val = {1'b1, {(SAMP_W-1){1'b0}}};
         else                  sat_val = {1'b0, {(SAMP_W-1){1'b1}}};
      end
   end

   // Coefficient bank: shadow captures every strobe, active loads only in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow  <= '0;
         pending <= 1'b0;
         for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
      end else begin
         if (tapsValid) shadow <= allTaps;
         if (bank_load) begin
            pending <= 1'b0;
            for (int k = 0; k < NTAPS; k++)
               coef[k] <= tapsValid ? allTaps[k*COEF_W +: COEF_W]
                                    : shadow[k*COEF_W +: COEF_W];
         end else if (tapsValid) begin
            pending <= 1'b1;
         end
      end
   end

   // Sample history ring and write pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         base   <= '0;
         for (int k = 0; k < NTAPS; k++) hist[k] <= '0;
      end else if (accept) begin
         hist[wr_ptr] <= sampleIn;
         base         <= wr_ptr;
         wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
   end

   // Accumulator and tap index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         idx <= '0;
      end else if (accept) begin
         acc <= '0;
         idx <= '0;
      end else if (state == MAC) begin
         acc <= acc + prod_ext;
         idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

   // Registered filtered output and its one-cycle strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sampleOut <= '0;
         outValid  <= 1'b0;
      end else begin
         outValid <= (state == OUT);
         if (state == OUT) sampleOut <= sat_val;
      end
   end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller for the equalizer filter path. It owns the sample history buffer and the active coefficient bank, and shares one signed multiply-accumulate unit across all taps. For each accepted audio sample it produces one filtered, saturated output. It sits between the tap generator (`all_taps`, which drives `allTaps`) and the audio output stage.

## Interface
- NTAPS, 128, number of filter taps; bench uses 4
- COEF_W, 16, coefficient width, signed Q1.15
- SAMP_W, 16, sample width, signed Q1.15
- ACC_W, 40, accumulator width, signed
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- allTaps  in  NTAPS*COEF_W  coefficient vector; coef k = allTaps[k*COEF_W +: COEF_W]; coef 0 applies to the newest sample
- tapsValid  in  1  one-cycle strobe: allTaps holds a new bank
- sampleIn  in  SAMP_W  input sample
- sampleValid  in  1  sampleIn valid
- sampleReady  out  1  block can accept a sample; equals (state==IDLE)
- sampleOut  out  SAMP_W  filtered sample, registered
- outValid  out  1  one-cycle strobe: sampleOut valid
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE: on sampleValid&&sampleReady:
  - write sampleIn to hist[wrPtr];
  - base <= wrPtr; wrPtr <= (wrPtr+1) mod NTAPS;
  - acc <= 0; idx <= 0; go to MAC.
- MAC: each cycle, acc += coef[idx] * hist[(base - idx) mod NTAPS].
  - Product is full 2*COEF_W signed, sign-extended to ACC_W.
  - idx increments. After the idx=NTAPS-1 accumulate, go to OUT.
- OUT: sampleOut <= sat(acc >>> (COEF_W-1)), clipped to [0x8000, 0x7FFF]. outValid <= 1 for one cycle. Go to IDLE.
- Coefficient bank:
  - tapsValid in any state copies allTaps into the shadow register and sets pending.
  - An edge in IDLE with pending, or with tapsValid, loads the active bank. A direct tapsValid in IDLE loads allTaps directly. pending is cleared.
  - The active bank never changes during MAC/OUT. An in-flight output always uses one consistent bank.
- Simultaneous tapsValid and sample accept in IDLE: the bank loads on the same edge, and that sample's MAC uses the new bank.
- tapsValid repeated while pending: the latest allTaps wins.
- sampleValid while busy: ignored. Upstream holds the sample until sampleReady.
- History wraps modulo NTAPS. Non-power-of-2 NTAPS uses explicit wrap compare.

## Timing
- Reset (reset=0, async) values:
  - state=IDLE, wrPtr=0, idx=0, acc=0, pending=0;
  - hist[] and the active bank all zero;
  - sampleOut=0, outValid=0, busy=0, sampleReady=1.
- Accept on edge E:
  - MAC accumulates on edges E+1 … E+NTAPS;
  - OUT is state after E+NTAPS;
  - sampleOut/outValid register on edge E+NTAPS+1.
- Latency from accept edge to outValid high: NTAPS+1 cycles.
- Throughput: one sample per NTAPS+2 cycles.
- outValid high coincides with IDLE. A new sample may be accepted in that same cycle.
- Reset mid-MAC/OUT: the operation is aborted, no outValid is produced, and history is cleared.

## Test plan
- Reset: assert reset=0 mid-run.
  - Outputs immediately go to sampleOut=0, outValid=0, busy=0, sampleReady=1.
  - After release, a zero-coefficient bank yields 0x0000 for input 0x7FFF.
- Impulse (NTAPS=4): load coefs {0x4000,0x2000,0x1000,0x0800}, then feed 0x7FFF,0,0,0.
  - Required outputs: 0x3FFF, 0x1FFF, 0x0FFF, 0x07FF.
  - Each outValid is 5 cycles after its accept edge.
- Saturation: all coefs 0x7FFF.
  - Four samples of 0x7FFF: fourth output = 0x7FFF.
  - Then four samples of 0x8000: output reaches 0x8000 with no wrap.
- Bank switch during MAC: bank A = {0x4000,0,0,0}, impulse 0x7FFF. Pulse tapsValid with B = {0x2000,0,0,0} at MAC cycle 2.
  - Current output = 0x3FFF.
  - Next sample 0x7FFF gives 0x1FFF.
  - pending clears on entry to IDLE.
- Backpressure: hold sampleValid=1 continuously with incrementing samples.
  - Accepts occur exactly every 6 cycles.
  - No sample is skipped or duplicated, checked against a reference FIR model.
- Simultaneous: tapsValid and sampleValid in the same IDLE cycle.
  - Output reflects the new bank: coefs {0x4000,…}, impulse 0x7FFF → 0x3FFF.
